// File: rtl/baby_ram_pkg.sv
// Shared constants and state type for the Manchester Baby RAM responder.
package baby_ram_pkg;

  localparam int BABY_ADDR_W    = 5;
  localparam int BABY_WORD_W    = 32;
  localparam int BYTES_PER_WORD = BABY_WORD_W / 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2
  } state_e;

endpackage

// File: rtl/baby_ram_array.sv
// Word store with async clear, one write port and one combinational read port.
module baby_ram_array
  import baby_ram_pkg::*;
#(
  parameter int ADDR_W = BABY_ADDR_W,
  parameter int WORD_W = BABY_WORD_W
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/baby_ram_responder.sv
// Baby CPU RAM responder with a byte-wide host port for bulk load and dump.
//   state | meaning
//   RUN   | CPU owns memory; host load/dump requests sampled
//   LOAD  | host streams bytes into memory, CPU held off
//   DUMP  | memory streamed out byte by byte, CPU held off
module baby_ram_responder
  import baby_ram_pkg::*;
#(
  parameter int ADDR_W = BABY_ADDR_W,
  parameter int WORD_W = BABY_WORD_W
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic              ram_rw_en_i,
  input  logic [WORD_W-1:0] ram_data_i,
  output logic [WORD_W-1:0] ram_data_o,
  output logic              cpu_hold_o,
  input  logic              load_i,
  input  logic              dump_i,
  input  logic              host_valid_i,
  input  logic [7:0]        host_data_i,
  output logic              host_ready_o,
  output logic              dump_valid_o,
  output logic [7:0]        dump_data_o,
  input  logic              dump_ready_i,
  output logic              done_o
);

  localparam int BYTES = WORD_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = '1;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] word_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic [WORD_W-1:0] asm_q, load_word, rd_word, wdata;
  logic [ADDR_W-1:0] waddr, raddr;
  logic              we, done_q, advance, word_end, last_byte;

  baby_ram_array #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_array (
    .clock   (clock),
    .reset_i (reset_i),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rd_word)
  );

  // Incoming host byte merged into its lane; written whole when the top lane arrives.
  always_comb begin
    load_word = asm_q;
    load_word[8*byte_cnt +: 8] = host_data_i;
  end

  assign word_end  = (byte_cnt == LAST_BYTE);
  assign last_byte = word_end && (word_cnt == LAST_WORD);
  assign advance   = ((state == LOAD) && host_valid_i) || ((state == DUMP) && dump_ready_i);
  assign done_o    = done_q;

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cpu_hold_o   = 1'b0;
    host_ready_o = 1'b0;
    dump_valid_o = 1'b0;
    dump_data_o  = '0;
    ram_data_o   = '0;
    we           = 1'b0;
    waddr        = ram_addr_i;
    wdata        = ram_data_i;
    raddr        = ram_addr_i;
    case (state)
      RUN: begin
        ram_data_o = rd_word;
        we         = ram_rw_en_i;
        if (load_i)      state_nxt = LOAD;
        else if (dump_i) state_nxt = DUMP;
      end
      LOAD: begin
        cpu_hold_o   = 1'b1;
        host_ready_o = 1'b1;
        waddr        = word_cnt;
        wdata        = load_word;
        we           = host_valid_i && word_end;
        if (host_valid_i && last_byte) state_nxt = RUN;
      end
      DUMP: begin
        cpu_hold_o   = 1'b1;
        dump_valid_o = 1'b1;
        raddr        = word_cnt;
        dump_data_o  = rd_word[8*byte_cnt +: 8];
        if (dump_ready_i && last_byte) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Counters sit at zero throughout RUN, so either transfer starts from byte 0.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= advance && last_byte;
      if (state == RUN) begin
        word_cnt <= '0;
        byte_cnt <= '0;
      end else if (advance) begin
        if (word_end) begin
          byte_cnt <= '0;
          word_cnt <= word_cnt + 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
      if ((state == LOAD) && host_valid_i) asm_q <= word_end ? '0 : load_word;
    end
  end

endmodule

// File: tb/tb_baby_ram_responder.sv
// Scoreboard bench for baby_ram_responder against an array-based memory model.
module tb_baby_ram_responder;

  localparam int DEPTH  = 32;
  localparam int NBYTES = 128;

  logic        clock = 1'b0;
  logic        reset_i = 1'b1;
  logic [4:0]  ram_addr_i = '0;
  logic        ram_rw_en_i = 1'b0;
  logic [31:0] ram_data_i = '0;
  logic [31:0] ram_data_o;
  logic        cpu_hold_o;
  logic        load_i = 1'b0;
  logic        dump_i = 1'b0;
  logic        host_valid_i = 1'b0;
  logic [7:0]  host_data_i = '0;
  logic        host_ready_o;
  logic        dump_valid_o;
  logic [7:0]  dump_data_o;
  logic        dump_ready_i = 1'b0;
  logic        done_o;

  baby_ram_responder dut (
    .clock        (clock),
    .reset_i      (reset_i),
    .ram_addr_i   (ram_addr_i),
    .ram_rw_en_i  (ram_rw_en_i),
    .ram_data_i   (ram_data_i),
    .ram_data_o   (ram_data_o),
    .cpu_hold_o   (cpu_hold_o),
    .load_i       (load_i),
    .dump_i       (dump_i),
    .host_valid_i (host_valid_i),
    .host_data_i  (host_data_i),
    .host_ready_o (host_ready_o),
    .dump_valid_o (dump_valid_o),
    .dump_data_o  (dump_data_o),
    .dump_ready_i (dump_ready_i),
    .done_o       (done_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int hold_cnt = 0;
  int done_cnt = 0;
  logic        rd_req = 1'b0;
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_dump[$];
  logic [31:0] model [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    total++;
    bad++;
    $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Monitor: consumes expected responses whenever the DUT presents them.
  always @(negedge clock) begin
    if (cpu_hold_o) hold_cnt++;
    if (done_o) done_cnt++;
    if (rd_req) begin
      if (exp_rd.size() == 0) fail_now("read_underflow", 0, 1);
      else check("ram_read", ram_data_o, exp_rd.pop_front());
    end
    if (dump_valid_o) begin
      if (exp_dump.size() == 0) fail_now("dump_underflow", 0, 1);
      else begin
        check("dump_byte", {24'd0, dump_data_o}, {24'd0, exp_dump[0]});
        if (dump_ready_i) void'(exp_dump.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_word(input int a, input logic [31:0] e);
    ram_rw_en_i = 1'b0;
    ram_addr_i  = a[4:0];
    rd_req      = 1'b1;
    exp_rd.push_back(e);
    step();
    rd_req = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    ram_rw_en_i = 1'b1;
    ram_addr_i  = a[4:0];
    ram_data_i  = d;
    model[a]    = d;
    step();
    ram_rw_en_i = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) read_word(a, model[a]);
  endtask

  task automatic do_load(input bit stall, input bit noise, input bit simul, input int limit, input bit rnd);
    logic [7:0] b [NBYTES];
    int k = 0;
    int cyc = 0;
    int hold0, done0;
    bit acc;
    for (int i = 0; i < NBYTES; i++) b[i] = rnd ? 8'($urandom_range(0, 255)) : i[7:0];
    load_i = 1'b1;
    if (simul) begin
      dump_i      = 1'b1;
      ram_rw_en_i = 1'b1;
      ram_addr_i  = 5'd3;
      ram_data_i  = 32'h12345678;
      model[3]    = 32'h12345678;
    end
    hold0 = hold_cnt;
    done0 = done_cnt;
    step();
    load_i = 1'b0;
    dump_i = 1'b0;
    ram_rw_en_i = 1'b0;
    ram_addr_i = 5'd7;
    check("load_entry_hold", {31'd0, cpu_hold_o}, 32'd1);
    check("load_entry_ready", {31'd0, host_ready_o}, 32'd1);
    check("load_entry_no_dump", {31'd0, dump_valid_o}, 32'd0);
    check("load_ram_data_zero", ram_data_o, 32'd0);
    while (k < limit && cyc < 600) begin
      host_valid_i = stall ? cyc[0] : 1'b1;
      host_data_i  = b[k];
      if (noise && k >= 8) begin
        ram_rw_en_i = 1'b1;
        ram_addr_i  = 5'd0;
        ram_data_i  = $urandom;
      end
      @(negedge clock);
      acc = host_valid_i && host_ready_o;
      step();
      if (acc) k++;
      cyc++;
    end
    host_valid_i = 1'b0;
    ram_rw_en_i  = 1'b0;
    if (k < limit) fail_now("load_timeout", k, limit);
    if (limit == NBYTES) begin
      for (int w = 0; w < DEPTH; w++) model[w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
      check("load_done_first_run", {31'd0, done_o}, 32'd1);
      check("load_hold_released", {31'd0, cpu_hold_o}, 32'd0);
      check("load_cycles", cyc, stall ? 32'd256 : 32'd128);
      repeat (3) step();
      check("load_hold_cycles", hold_cnt - hold0, stall ? 32'd256 : 32'd128);
      check("load_done_pulses", done_cnt - done0, 32'd1);
    end
  endtask

  task automatic do_dump(input int mode);
    int n = 0;
    int cyc = 0;
    int done0;
    bit acc;
    for (int i = 0; i < NBYTES; i++) exp_dump.push_back(model[i/4][8*(i%4) +: 8]);
    dump_i = 1'b1;
    done0 = done_cnt;
    step();
    dump_i = 1'b0;
    check("dump_entry_valid", {31'd0, dump_valid_o}, 32'd1);
    check("dump_entry_hold", {31'd0, cpu_hold_o}, 32'd1);
    check("dump_ram_data_zero", ram_data_o, 32'd0);
    while (n < NBYTES && cyc < 1000) begin
      dump_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      @(negedge clock);
      acc = dump_valid_o && dump_ready_i;
      step();
      if (acc) n++;
      cyc++;
    end
    dump_ready_i = 1'b0;
    if (n < NBYTES) fail_now("dump_timeout", n, NBYTES);
    check("dump_done_first_run", {31'd0, done_o}, 32'd1);
    check("dump_valid_released", {31'd0, dump_valid_o}, 32'd0);
    check("dump_queue_drained", exp_dump.size(), 32'd0);
    repeat (2) step();
    check("dump_done_pulses", done_cnt - done0, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("rst_ready", {31'd0, host_ready_o}, 32'd0);
    check("rst_dump_valid", {31'd0, dump_valid_o}, 32'd0);
    check("rst_dump_data", {24'd0, dump_data_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    reset_i = 1'b0;
    step();

    read_word(7, 32'd0);
    write_word(7, 32'hDEADBEEF);
    read_word(7, 32'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) write_word(a, $urandom);
      else read_word(a, model[a]);
    end

    do_load(1'b0, 1'b0, 1'b0, NBYTES, 1'b0);
    read_word(1, 32'h07060504);
    read_word(31, 32'h7F7E7D7C);
    read_all();
    do_dump(1);

    for (int i = 0; i < 8; i++) write_word($urandom_range(0, DEPTH - 1), $urandom);
    do_load(1'b1, 1'b0, 1'b0, NBYTES, 1'b0);
    read_word(1, 32'h07060504);
    read_word(31, 32'h7F7E7D7C);
    read_all();

    do_load(1'b0, 1'b1, 1'b1, NBYTES, 1'b1);
    read_all();
    do_dump(2);

    do_load(1'b0, 1'b0, 1'b0, 50, 1'b1);
    #1 reset_i = 1'b1;
    #1;
    check("mid_rst_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("mid_rst_ready", {31'd0, host_ready_o}, 32'd0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    step();
    step();
    reset_i = 1'b0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    step();
    check("post_rst_hold", {31'd0, cpu_hold_o}, 32'd0);
    read_all();
    write_word(9, 32'hCAFEF00D);
    read_word(9, 32'hCAFEF00D);

    repeat (2) step();
    check("read_queue_drained", exp_rd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
